muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core, parametrised in datapath width.
- Sits beside the ALU in the EX stage and accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Raises a stall request to the hazard logic while an operation is in flight, so the pipeline holds any dependent access or second issue.
- Supports flush (branch squash) and defines results for divide-by-zero and signed overflow.

## Interface

Parameters:
- WIDTH, 32, operand/HI/LO width; must be even and ≥ 4
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- start  in  1  issue strobe from EX; op/a/b valid when high
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- b  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  squash in-flight operation and any same-cycle start
- rd_req  in  1  MFHI/MFLO present in EX this cycle
- busy  out  1  iterative operation in progress (registered)
- stall  out  1  combinational: busy & (rd_req | start)
- done  out  1  one-cycle pulse, HI/LO just updated by MULT/DIV family
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation

States:
- IDLE: accepts work.
- ITER: WIDTH iterations.
- FIX: sign correction and HI/LO commit.

Signed handling:
- MULT/DIV operate on absolute values of a and b, then correct signs in FIX.
- Product is negated if the operand signs differ.
- Quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Absolute value of −2^(WIDTH−1) is treated as the unsigned value 2^(WIDTH−1).

Algorithms:
- Multiply: radix-2 shift-add on a 2·WIDTH accumulator, one multiplier bit per ITER cycle.
- Divide: radix-2 restoring, one quotient bit per ITER cycle, with a WIDTH+1-bit partial remainder.

Results:
- HI = upper product half or remainder.
- LO = lower product half or quotient.

Special cases:
- **Divide by zero** (b == 0, DIV or DIVU): LO = all ones, HI = a. Latency is unchanged and done still pulses.
- **Signed overflow** (DIV −2^(WIDTH−1) / −1): LO = 0x8000…0, HI = 0 (wraps).
- **MTHI/MTLO**: in IDLE with start, HI (or LO) ← a at the next edge. No busy, no done.

Issue and flush:
- start is ignored while busy. The pipeline is responsible for holding the instruction via stall.
- flush aborts at the next edge: return to IDLE, HI/LO unchanged, no done.
- flush and start in the same cycle: start is discarded, including MTHI/MTLO.
- Reserved op codes with start: no state change.

## Timing

Reset (rst = 0), asynchronous:
- state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0.
- Internal accumulators are cleared.

Reset mid-operation: the operation is lost; HI/LO = 0.

MULT/DIV family, with start sampled at edge E0:
- busy = 1 from after E0 through the cycle before E(WIDTH+1), i.e. WIDTH+1 cycles.
- ITER covers edges E1..E(WIDTH); FIX commits HI/LO at E(WIDTH+1).
- done = 1 for exactly the cycle after E(WIDTH+1); busy = 0 in that cycle.
- A new start is accepted in the done cycle, giving back-to-back throughput of WIDTH+2 cycles per operation.
- An MFHI/MFLO issued in the done cycle sees the new values.

Other timing:
- MTHI/MTLO: latency 1 edge. An MFHI in the following cycle sees the written value.
- stall is purely combinational, with no added latency, and is 0 whenever busy = 0.
- hi/lo are register outputs and change only at reset, a FIX edge, or an MTHI/MTLO edge.

## Test plan

- **MULTU, WIDTH = 32, a = b = 0xFFFFFFFF**
  - Required: busy for 33 cycles, then a done pulse with hi = 0xFFFFFFFE, lo = 0x00000001.
- **Signed multiply and divide**
  - MULT a = −3 (0xFFFFFFFD), b = 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
  - DIV a = −7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU a = 100, b = 7 → lo = 14, hi = 2.
- **Edge cases**
  - DIV a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
  - DIVU a = 0x1234, b = 0 → lo = 0xFFFFFFFF, hi = 0x1234, with done after 33 busy cycles.
- **Flush and reset mid-operation**
  - Preload MTHI 0xAAAA and MTLO 0x5555, start MULTU, assert flush on the 10th busy cycle.
  - Required: busy = 0 next cycle, no done, hi/lo still 0xAAAA/0x5555.
  - Repeat with rst pulsed low instead of flush → hi = lo = 0 immediately, busy = 0.
- **Stall handshake**
  - During DIV, drive rd_req = 1 → stall = 1 every busy cycle and 0 in the done cycle.
  - A start while busy → stall = 1, and HI/LO reflect only the first operation.
  - Flush together with start in IDLE → no busy, HI/LO unchanged.
- **Parametrised build WIDTH = 8**
  - MULT 0x80 × 0x80 → hi = 0x40, lo = 0x00 after 9 busy cycles.
  - DIV 0x80 / 0xFF → lo = 0x80, hi = 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by one sign-fix cycle that commits HI/LO. MTHI/MTLO write in
// a single edge. A stall request holds the pipeline while work is in flight.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half shifts dividend bits out and quotient bits in.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;       // partial remainder between iterations
    logic [WIDTH-1:0]   opnd;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   a_raw;     // original dividend for divide-by-zero
    logic               is_div;
    logic               neg_res;   // product / quotient needs negation
    logic               neg_rem;   // remainder takes dividend's sign
    logic               div_zero;

    // Issue decode and operand magnitudes
    logic               accept;
    logic               is_signed_op;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;  // WIDTH+1-bit trial partial remainder
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    // Sign-corrected results for the FIX commit
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign accept       = (state == IDLE) && start && !flush;
    assign is_signed_op = ~op[0];
    // Negating -2^(WIDTH-1) leaves the same bit pattern, read as unsigned 2^(WIDTH-1).
    assign a_abs        = (is_signed_op && a[WIDTH-1]) ? -a : a;
    assign b_abs        = (is_signed_op && b[WIDTH-1]) ? -b : b;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -rem : rem;

    assign stall = busy & (rd_req | start);

    // Result selection for the commit edge, including divide-by-zero override
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    // Next-state logic: WIDTH iterations, one fix cycle, flush returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !op[2]) state_next = ITER;
            ITER: begin
                if (flush)                            state_next = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered busy/done flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == FIX) && !flush;
        end
    end

    // Datapath: operand capture, iteration steps, HI/LO commit and MTHI/MTLO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!op[2]) begin
                            cnt      <= '0;
                            rem      <= '0;
                            is_div   <= op[1];
                            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                            opnd     <= op[1] ? b_abs : a_abs;
                            a_raw    <= a;
                            neg_res  <= is_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem  <= is_signed_op && a[WIDTH-1];
                            div_zero <= op[1] && (b == '0);
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ITER: begin
                    if (!flush) begin
                        cnt <= cnt + CNT_W'(1);
                        if (is_div) begin
                            rem              <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors with a result scoreboard for the
// 32-bit unit, hand sequences for flush/reset/stall corners, and an 8-bit
// build for the parametrised cases.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, rd_req;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    logic        start8, flush8, rd_req8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, stall8, done8;
    logic [7:0]  hi8, lo8;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    vec_t        vecs[12];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .rd_req(rd_req), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .rd_req(rd_req8), .busy(busy8), .stall(stall8),
        .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one start cycle at a negedge; returns just after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count busy cycles up to the done cycle, then compare against the scoreboard.
    task automatic wait_done(input string name, input int exp_busy, input bit chk_stall);
        int n = 0;
        logic [63:0] exp;
        @(negedge clk);
        check({name, "_done_low_in_busy"}, {63'd0, done}, 64'd0);
        while (busy && n < 100) begin
            n++;
            if (chk_stall) check({name, "_stall_busy"}, {63'd0, stall}, 64'd1);
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        check({name, "_done"}, {63'd0, done}, 64'd1);
        if (chk_stall) check({name, "_stall_done"}, {63'd0, stall}, 64'd0);
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check({name, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
            check({name, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
        end
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] x);
        issue(o, x, 32'd0);
        @(negedge clk);
    endtask

    task automatic run8(input string name, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] eh, input logic [7:0] el);
        int n = 0;
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        while (busy8 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(n), 64'd9);
        check({name, "_done"}, {63'd0, done8}, 64'd1);
        check({name, "_hi"}, {56'd0, hi8}, {56'd0, eh});
        check({name, "_lo"}, {56'd0, lo8}, {56'd0, el});
    endtask

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7]  = '{OP_MULT,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
        vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
        vecs[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[11] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

        rst = 1'b0; start = 1'b0; flush = 1'b0; rd_req = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; flush8 = 1'b0; rd_req8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        #12;
        check("reset_hi",    {32'd0, hi},     64'd0);
        check("reset_lo",    {32'd0, lo},     64'd0);
        check("reset_busy",  {63'd0, busy},   64'd0);
        check("reset_done",  {63'd0, done},   64'd0);
        check("reset_stall", {63'd0, stall},  64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back: each op is issued in the done cycle of the previous one.
        for (int i = 0; i < 12; i++) begin
            sb_q.push_back({vecs[i].hi, vecs[i].lo});
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), 33, 1'b0);
        end
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // MTHI/MTLO, then flush on the 10th busy cycle.
        mt(OP_MTHI, 32'hAAAA);
        check("mthi_hi",   {32'd0, hi},   64'hAAAA);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        mt(OP_MTLO, 32'h5555);
        check("mtlo_lo",   {32'd0, lo},   64'h5555);
        check("mtlo_done", {63'd0, done}, 64'd0);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_done", {63'd0, done}, 64'd0);
        check("flush_hi",   {32'd0, hi},   64'hAAAA);
        check("flush_lo",   {32'd0, lo},   64'h5555);
        @(negedge clk);
        check("flush_no_late_done", {63'd0, done}, 64'd0);

        // Reset in the middle of an operation.
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_hi",   {32'd0, hi},   64'd0);
        check("rstmid_lo",   {32'd0, lo},   64'd0);
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Stall with rd_req held through a divide.
        rd_req = 1'b1;
        sb_q.push_back({32'd2, 32'd14});
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("stall_div", 33, 1'b1);
        rd_req = 1'b0;
        @(negedge clk);

        // Start while busy is stalled and ignored.
        sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        for (int i = 0; i < 5; i++) @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        #1 check("busy_start_stall", {63'd0, stall}, 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("busy_start", 28, 1'b0);
        @(negedge clk);
        check("busy_start_not_queued", {63'd0, busy}, 64'd0);

        // Flush with start in IDLE, and a reserved op code.
        start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'hDEAD;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_mthi_hi", {32'd0, hi}, 64'hFFFFFFFF);
        start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_div_busy", {63'd0, busy}, 64'd0);
        check("flush_div_lo",   {32'd0, lo},   64'hFFFFFFF1);
        mt(OP_RSVD, 32'h1357);
        check("rsvd_busy", {63'd0, busy}, 64'd0);
        check("rsvd_hi",   {32'd0, hi},   64'hFFFFFFFF);
        check("rsvd_lo",   {32'd0, lo},   64'hFFFFFFF1);

        // 8-bit build.
        run8("w8_mult", OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00);
        @(negedge clk);
        run8("w8_div",  OP_DIV,  8'h80, 8'hFF, 8'h00, 8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
